// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scanner. The digits are captured once per
// frame, each slot opens with an all-off gap, and leading zeros can be blanked.
module seg7_scan_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_in,
  input  logic       lzb,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [PW-1:0] r_prescaler;
  logic [1:0]    r_idx;
  logic          r_load_pending;
  logic [3:0]    r_shadow [4];
  logic [3:0]    r_s_dp;

  logic       w_slot_end;
  logic       w_frame_load;
  logic       w_blank_slot;
  logic [3:0] w_din [4];
  logic [3:0] w_digit;
  logic       w_digit_blank;
  logic [6:0] w_seg;
  logic [3:0] w_an;

  assign w_din[0] = d0;
  assign w_din[1] = d1;
  assign w_din[2] = d2;
  assign w_din[3] = d3;

  assign w_slot_end   = (r_prescaler == PW'(REFRESH_DIV - 1));
  assign w_frame_load = r_load_pending | (w_slot_end & (r_idx == 2'd3));

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign w_blank_slot = 1'b0;
    end else begin : g_blank
      assign w_blank_slot = (r_prescaler < PW'(BLANK_CYCLES));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prescaler    <= '0;
      r_idx          <= 2'd0;
      r_load_pending <= 1'b1;
      r_s_dp         <= 4'h0;
      for (int i = 0; i < 4; i++) r_shadow[i] <= 4'h0;
    end else begin
      r_prescaler <= w_slot_end ? '0 : r_prescaler + 1'b1;
      if (w_slot_end) r_idx <= r_idx + 2'd1;
      // Snapshot lands together with the idx 3->0 wrap, so digit 0 of the new frame is coherent.
      if (w_frame_load) begin
        r_load_pending <= 1'b0;
        r_s_dp         <= dp_in;
        for (int i = 0; i < 4; i++) r_shadow[i] <= w_din[i];
      end
    end
  end

  always_comb begin
    w_digit       = r_shadow[r_idx];
    w_digit_blank = 1'b0;
    if (lzb) begin
      case (r_idx)
        2'd3:    w_digit_blank = (r_shadow[3] == 4'h0);
        2'd2:    w_digit_blank = (r_shadow[3] == 4'h0) && (r_shadow[2] == 4'h0);
        default: w_digit_blank = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (w_digit)
      4'd0:    w_seg = 7'h40;
      4'd1:    w_seg = 7'h79;
      4'd2:    w_seg = 7'h24;
      4'd3:    w_seg = 7'h30;
      4'd4:    w_seg = 7'h19;
      4'd5:    w_seg = 7'h12;
      4'd6:    w_seg = 7'h02;
      4'd7:    w_seg = 7'h78;
      4'd8:    w_seg = 7'h00;
      4'd9:    w_seg = 7'h10;
      default: w_seg = 7'h3F;
    endcase
  end

  assign w_an = ~(4'b0001 << r_idx);

  always_ff @(posedge clk) begin
    if (reset || w_blank_slot) begin
      an  <= 4'hF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      an  <= w_an;
      seg <= w_digit_blank ? 7'h7F : w_seg;
      dp  <= w_digit_blank ? 1'b1 : ~r_s_dp[r_idx];
    end
  end

endmodule
